usb_tx_pkt_seq: RTL
===================

Name: usb_tx_pkt_seq

Overview:
Parametrised USB data-packet transmit sequencer. It is the next generation of the team's simple tx_valid FSM test block.
- On a send request it emits a PID byte, then streams payload bytes from an upstream source, then appends the two CRC16 bytes. Every byte uses a valid/ready handshake toward the serialiser.
- It keeps a HIST_DEPTH-deep shift history of accepted beats, used to check FSM extraction quality, plus byte-count and error status.

Parameters:
HIST_DEPTH, 10, width of the beat-history shift register (>=2).
MAX_LEN, 64, maximum payload bytes per packet (1..1023).
LEN_W, 10, width of the payload byte counter (2^LEN_W > MAX_LEN).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
send_data  input  1  start request; sampled only in IDLE.
pid  input  4  PID nibble, captured when send_data is accepted.
in_data  input  8  payload byte.
in_valid  input  1  payload byte valid.
in_last  input  1  marks last payload byte; qualified by in_valid.
in_ready  output  1  payload byte accepted this cycle.
tx_data  output  8  byte to serialiser.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  serialiser accepts byte.
busy  output  1  high in any state other than IDLE.
pkt_len  output  LEN_W  payload bytes sent in last completed packet.
err_len  output  1  sticky: payload exceeded MAX_LEN.
hist  output  HIST_DEPTH  history of accepted tx beats.

Behaviour:
- Reset (reset=0, async): state=IDLE; tx_valid=0, in_ready=0, busy=0, pkt_len=0, err_len=0, hist=0, CRC reg=16'hFFFF, byte counter=0.
- Fire = tx_valid & tx_ready. Only fires advance state or counters.
- States and transitions:
  - IDLE: tx_valid=0. If send_data=1, capture pid, clear counter, set CRC=FFFF, clear err_len, go to PID next cycle. No zero-cycle start.
  - PID: tx_valid=1, tx_data={~pid,pid}. On fire go to DATA. PID byte is excluded from the CRC.
  - DATA: zero-latency passthrough. tx_data=in_data, tx_valid=in_valid, in_ready=tx_ready.
    - On fire: update CRC with the byte, count++ (saturating at 2^LEN_W-1).
    - If count reaches MAX_LEN and further bytes fire, set err_len.
    - Fire with in_last=1 goes to CRC1.
  - CRC1: tx_valid=1, tx_data=~crc[7:0]. On fire go to CRC2.
  - CRC2: tx_valid=1, tx_data=~crc[15:8]. On fire: pkt_len<=count, go to IDLE.
  - Zero-length packet: send_data with no payload is not supported. Upstream signals zero length by presenting in_valid=1, in_last=1, in_data ignored, while a zero-length flag is set. This is not supported in this revision; every packet carries at least 1 byte.
- CRC16-USB: polynomial x^16+x^15+x^2+1 (0x8005), reflected, LSB-first per byte, init FFFF, output complemented, low byte sent first.
- tx_valid, once asserted in PID/CRC1/CRC2, is held with tx_data stable until fire (no retraction).
- in_ready=0 outside DATA.
- hist: on every clock edge, hist <= {hist[HIST_DEPTH-2:0], fire}.
- send_data while busy is ignored.
- Unused state encodings return to IDLE with tx_valid=0.
- Reset mid-packet aborts immediately. pkt_len and err_len clear.

Optional Feature:
USB_TX_ABORT_EN
- Compiled in: adds input abort (1 bit). abort=1 in any non-IDLE state forces IDLE on the next edge, tx_valid=0 that cycle, pkt_len unchanged, and the 1-cycle pulse output aborted asserted. abort takes priority over a simultaneous fire.
- Compiled out: no abort/aborted ports; packets always complete.

Test Plan:
1. Reset with tx_ready=1, send_data=1 -> tx_valid=0, hist=0, busy=0 while reset=0. First PID beat appears 2 cycles after release plus send_data.
2. pid=4'h3, payload 00 01 02 03 (last on 03), tx_ready=1 -> bytes C3,00,01,02,03 then the 2 CRC bytes equal to the bench CRC16 model. pkt_len=4, hist low 7 bits all 1.
3. Same packet with tx_ready toggling 1/0 each cycle -> identical byte sequence, each byte held stable across stall cycles, 7 fires total.
4. MAX_LEN=4, payload of 6 bytes -> all 6 sent, err_len=1 after 5th fire, pkt_len=6. Next send_data clears err_len.
5. send_data pulsed during DATA -> ignored. After CRC2 fire, busy=0 and no second packet starts.
6. (USB_TX_ABORT_EN) abort in DATA after 2 bytes -> IDLE next cycle, aborted=1 for 1 cycle, pkt_len keeps prior value, next packet CRC correct.

Source files
------------

// File: rtl/usb_tx_pkt_seq.sv
// usb_tx_pkt_seq -- USB data-packet transmit sequencer.
//
// On a send request the block emits a PID byte, streams payload bytes from
// an upstream valid/ready source straight through to the serialiser, then
// appends the complemented CRC16-USB of the payload (low byte first). Every
// byte toward the serialiser uses a valid/ready handshake.
//
// Parameters:
//   HIST_DEPTH  width of the accepted-beat history shift register (>=2)
//   MAX_LEN     payload length above which err_len_o is raised
//   LEN_W       width of the payload byte counter (2**LEN_W > MAX_LEN)
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-low reset
//   send_data_i  start request, sampled only while idle
//   pid_i        PID nibble, captured with the start request
//   in_data_i / in_valid_i / in_last_i / in_ready_o   upstream payload
//   tx_data_o / tx_valid_o / tx_ready_i               serialiser side
//   busy_o       high whenever a packet is in progress
//   pkt_len_o    payload bytes of the last completed packet
//   err_len_o    sticky: payload ran past MAX_LEN (cleared on next start)
//   hist_o       one bit per clock, 1 where a tx beat was accepted
//
// Optional build macro USB_TX_ABORT_EN adds:
//   abort_i      abandon the current packet, back to idle on the next edge
//   aborted_o    one-cycle pulse after an abort took effect
//
// State table:
//   S_IDLE | waiting for send_data_i, no tx beat offered
//   S_PID  | offering {~pid, pid}
//   S_DATA | payload passthrough, CRC and byte count updated per beat
//   S_CRC1 | offering ~crc[7:0]
//   S_CRC2 | offering ~crc[15:8], packet length latched on accept

module usb_tx_pkt_seq #(
  parameter int HIST_DEPTH = 10,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  send_data_i,
  input  logic [3:0]            pid_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic [LEN_W-1:0]      pkt_len_o,
  output logic                  err_len_o,
  output logic [HIST_DEPTH-1:0] hist_o
`ifdef USB_TX_ABORT_EN
  ,
  input  logic                  abort_i,
  output logic                  aborted_o
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PID  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CRC1 = 3'd3;
  localparam logic [2:0] S_CRC2 = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [3:0]            pid_q, pid_d;
  logic [15:0]           crc_q, crc_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  err_q, err_d;
  logic [HIST_DEPTH-1:0] hist_q;
  logic                  fire;
  logic                  abort_act;

  // Reflected CRC16 (0x8005 -> 0xA001), data consumed LSB first.
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    end
    return x;
  endfunction

`ifdef USB_TX_ABORT_EN
  logic aborted_q;
  assign abort_act = abort_i & (state_q != S_IDLE);
  assign aborted_o = aborted_q;
`else
  assign abort_act = 1'b0;
`endif

  // Handshake outputs. An abort suppresses the beat so it can never fire
  // in the same cycle the packet is being abandoned.
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    in_ready_o = 1'b0;
    case (state_q)
      S_PID: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {~pid_q, pid_q};
      end
      S_DATA: begin
        tx_valid_o = in_valid_i;
        tx_data_o  = in_data_i;
        in_ready_o = tx_ready_i;
      end
      S_CRC1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ~crc_q[7:0];
      end
      S_CRC2: begin
        tx_valid_o = 1'b1;
        tx_data_o  = ~crc_q[15:8];
      end
      default: ;
    endcase
    if (abort_act) begin
      tx_valid_o = 1'b0;
      in_ready_o = 1'b0;
    end
  end

  assign fire = tx_valid_o & tx_ready_i;

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    crc_d   = crc_q;
    count_d = count_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (send_data_i) begin
          pid_d   = pid_i;
          crc_d   = 16'hFFFF;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_PID;
        end
      end
      S_PID: if (fire) state_d = S_DATA;
      S_DATA: begin
        if (fire) begin
          crc_d = crc_next(crc_q, in_data_i);
          if (count_q != {LEN_W{1'b1}}) count_d = count_q + 1'b1;
          if (count_q >= LEN_W'(MAX_LEN)) err_d = 1'b1;
          if (in_last_i) state_d = S_CRC1;
        end
      end
      S_CRC1: if (fire) state_d = S_CRC2;
      S_CRC2: begin
        if (fire) begin
          len_d   = count_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      pid_q   <= 4'h0;
      crc_q   <= 16'hFFFF;
      count_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      crc_q   <= crc_d;
      count_q <= count_d;
      len_q   <= len_d;
      err_q   <= err_d;
      hist_q  <= {hist_q[HIST_DEPTH-2:0], fire};
    end
  end

`ifdef USB_TX_ABORT_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) aborted_q <= 1'b0;
    else          aborted_q <= abort_act;
  end
`endif

  assign busy_o    = (state_q != S_IDLE);
  assign pkt_len_o = len_q;
  assign err_len_o = err_q;
  assign hist_o    = hist_q;

endmodule
